// File: rtl/vga_framebuffer_dbuf.sv
// Double-buffered VGA framebuffer: scans the front bank, writes and clears go to the back bank,
// and bank swaps are deferred to the vblank edge so a displayed frame never tears.
module vga_framebuffer_dbuf #(
  parameter int         HACTIVE     = 640,
  parameter int         HFP         = 16,
  parameter int         HSYNC       = 96,
  parameter int         HBP         = 48,
  parameter int         VACTIVE     = 480,
  parameter int         VFP         = 10,
  parameter int         VSYNC       = 2,
  parameter int         VBP         = 33,
  parameter int         COLOR_MODE  = 0,
  parameter logic [7:0] CLEAR_VALUE = 8'h00
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic [7:0]  VGA_Cin,
  input  logic        pixel_write,
  input  logic        swap_req,
  input  logic        clear_req,
  output logic        swap_pending,
  output logic        clear_busy,
  output logic        vblank_start,
  output logic        front_sel,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic [9:0]  VGA_X,
  output logic [9:0]  VGA_Y,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N
);
  localparam int HTOTAL = HACTIVE + HFP + HSYNC + HBP;
  localparam int VTOTAL = VACTIVE + VFP + VSYNC + VBP;
  localparam int NPIX   = HACTIVE * VACTIVE;
  localparam int AW     = $clog2(NPIX);

  localparam logic [10:0]   H_LAST     = 11'(2 * HTOTAL - 1);
  localparam logic [10:0]   V_LAST     = 11'(VTOTAL - 1);
  localparam logic [10:0]   V_ACT_LAST = 11'(VACTIVE - 1);
  localparam logic [10:0]   V_ACT      = 11'(VACTIVE);
  localparam logic [10:0]   V_VS0      = 11'(VACTIVE + VFP);
  localparam logic [10:0]   V_VS1      = 11'(VACTIVE + VFP + VSYNC);
  localparam logic [9:0]    P_ACT      = 10'(HACTIVE);
  localparam logic [9:0]    P_HS0      = 10'(HACTIVE + HFP);
  localparam logic [9:0]    P_HS1      = 10'(HACTIVE + HFP + HSYNC);
  localparam logic [10:0]   X_LIM      = 11'(HACTIVE);
  localparam logic [10:0]   Y_LIM      = 11'(VACTIVE);
  localparam logic [AW-1:0] A_LAST     = AW'(NPIX - 1);

  typedef enum logic [1:0] {S_IDLE, S_PENDING, S_SWAP} state_t;

  logic [10:0]   hcount, vcount;
  logic [9:0]    p;
  logic          end_of_line, vblank_edge, blank;
  logic [AW-1:0] clear_cnt, wr_addr, rd_addr, wa;
  logic          wr_en;
  logic [7:0]    wd, pix, r_map, g_map, b_map;
  logic          blank_n_q;
  state_t        state, state_nxt;
  logic          do_swap;

  logic [7:0] mem0 [NPIX];
  logic [7:0] mem1 [NPIX];

  assign p           = hcount[10:1];
  assign end_of_line = (hcount == H_LAST);
  assign vblank_edge = end_of_line && (vcount == V_ACT_LAST);
  assign blank       = (p >= P_ACT) || (vcount >= V_ACT);
  assign wr_addr     = AW'(32'(x) + 32'(y) * HACTIVE);
  assign rd_addr     = AW'(32'(p) + 32'(vcount) * HACTIVE);

  assign VGA_X        = p;
  assign VGA_Y        = vcount[9:0];
  assign VGA_CLK      = hcount[0];
  assign VGA_HS       = ~((p >= P_HS0) && (p < P_HS1));
  assign VGA_VS       = ~((vcount >= V_VS0) && (vcount < V_VS1));
  assign VGA_SYNC_N   = 1'b1;
  assign VGA_BLANK_N  = blank_n_q;
  assign swap_pending = (state == S_PENDING);

  // The clear engine owns the write port; a clear_req in the same cycle also wins over pixel_write.
  always_comb begin
    wr_en = 1'b0;
    wa    = wr_addr;
    wd    = VGA_Cin;
    if (clear_busy) begin
      wr_en = 1'b1;
      wa    = clear_cnt;
      wd    = CLEAR_VALUE;
    end else if (pixel_write && !clear_req && (x < X_LIM) && (y < Y_LIM)) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (wr_en) begin
      if (front_sel) mem0[wa] <= wd;
      else           mem1[wa] <= wd;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pix       <= 8'h00;
      blank_n_q <= 1'b0;
    end else if (hcount[0]) begin
      blank_n_q <= ~blank;
      pix       <= blank ? 8'h00 : (front_sel ? mem1[rd_addr] : mem0[rd_addr]);
    end
  end

  // SWAP is a one-cycle acknowledge state; front_sel flips on the edge that enters it.
  always_comb begin
    state_nxt = state;
    do_swap   = 1'b0;
    case (state)
      S_IDLE:    if (swap_req) state_nxt = S_PENDING;
      S_PENDING: if (vblank_edge && !clear_busy) begin
                   state_nxt = S_SWAP;
                   do_swap   = 1'b1;
                 end
      S_SWAP:    state_nxt = swap_req ? S_PENDING : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      hcount       <= 11'd0;
      vcount       <= 11'd0;
      state        <= S_IDLE;
      front_sel    <= 1'b0;
      vblank_start <= 1'b0;
      clear_busy   <= 1'b0;
      clear_cnt    <= '0;
    end else begin
      state        <= state_nxt;
      vblank_start <= vblank_edge;
      if (do_swap) front_sel <= ~front_sel;
      if (end_of_line) begin
        hcount <= 11'd0;
        vcount <= (vcount == V_LAST) ? 11'd0 : vcount + 11'd1;
      end else begin
        hcount <= hcount + 11'd1;
      end
      if (clear_busy) begin
        clear_cnt <= clear_cnt + AW'(1);
        if (clear_cnt == A_LAST) clear_busy <= 1'b0;
      end else if (clear_req) begin
        clear_busy <= 1'b1;
        clear_cnt  <= '0;
      end
    end
  end

  always_comb begin
    if (COLOR_MODE == 1) begin
      r_map = {pix[7:5], pix[7:5], pix[7:6]};
      g_map = {pix[4:2], pix[4:2], pix[4:3]};
      b_map = {pix[1:0], pix[1:0], pix[1:0], pix[1:0]};
    end else begin
      r_map = pix;
      g_map = pix;
      b_map = pix;
    end
  end

  assign VGA_R = blank_n_q ? r_map : 8'h00;
  assign VGA_G = blank_n_q ? g_map : 8'h00;
  assign VGA_B = blank_n_q ? b_map : 8'h00;

endmodule

// File: doc/vga_framebuffer_dbuf.md
# vga_framebuffer_dbuf

Double-buffered, parametrised successor to the 640x480 VGA framebuffer. Drives the DE1 VGA DAC from CLOCK_50 (one pixel every two cycles). The drawing logic writes into a back buffer while the front buffer is scanned out. Buffers swap only on request and only at the start of vertical blank, so frames never tear. A hardware clear engine fills the back buffer with a constant, and RGB332 colour mode is available alongside the greyscale mode.

## Interface
- HACTIVE, 640: visible pixels per line
- HFP / HSYNC / HBP, 16 / 96 / 48: horizontal porch and sync widths, in pixels
- VACTIVE, 480: visible lines
- VFP / VSYNC / VBP, 10 / 2 / 33: vertical porch and sync widths, in lines
- COLOR_MODE, 0: 0 = 8-bit grey (R=G=B=pixel); 1 = RGB332
- CLEAR_VALUE, 8'h00: fill value used by the clear engine
- CLOCK_50  in  1: 50 MHz clock; the only clock
- reset  in  1: asynchronous, active-high
- x, y  in  11 each: write coordinates into the back buffer
- VGA_Cin  in  8: pixel data to write
- pixel_write  in  1: write strobe, one pixel per cycle
- swap_req  in  1: single-cycle pulse requesting a buffer swap
- clear_req  in  1: single-cycle pulse starting a back-buffer clear
- swap_pending  out  1: swap requested but not yet applied
- clear_busy  out  1: clear engine is running
- vblank_start  out  1: one-cycle pulse at the start of vertical blank
- front_sel  out  1: index of the bank being displayed
- VGA_R, VGA_G, VGA_B  out  8 each: colour outputs
- VGA_X, VGA_Y  out  10 each: current scan pixel (hcount>>1, vcount)
- VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N  out  1 each: DAC control signals

## Operation
- **Horizontal counter.** hcount runs 0..2*(HACTIVE+HFP+HSYNC+HBP)-1 and wraps. Pixel index p = hcount>>1.
- **Vertical counter.** vcount increments at end of line and wraps after VACTIVE+VFP+VSYNC+VBP-1.
- **Sync.** VGA_HS is low for p in [HACTIVE+HFP, HACTIVE+HFP+HSYNC). VGA_VS is low for vcount in [VACTIVE+VFP, VACTIVE+VFP+VSYNC). VGA_SYNC_N is tied to 1.
- **Clocks.** VGA_CLK = hcount[0].
- **Blanking.** blank = (p >= HACTIVE) | (vcount >= VACTIVE).
- **Memory.** Two banks of HACTIVE*VACTIVE x 8 bits. Address = x + y*HACTIVE, with width $clog2(HACTIVE*VACTIVE).
  - Scan-out reads bank front_sel.
  - All writes target bank ~front_sel.
- **Writes.**
  - pixel_write with x >= HACTIVE or y >= VACTIVE is silently dropped.
  - pixel_write is ignored while clear_busy.
- **Clear engine.**
  - clear_req while idle sets clear_busy and a counter to 0.
  - Each cycle it writes CLEAR_VALUE to the back bank and increments.
  - After writing address HACTIVE*VACTIVE-1, clear_busy drops.
  - clear_req while busy is ignored.
- **Swap state machine.** Three states: IDLE, PENDING, SWAP.
  - swap_req in IDLE moves to PENDING. swap_req in PENDING is a no-op.
  - In PENDING, at the vblank edge (endOfLine && vcount == VACTIVE-1) with clear_busy == 0, front_sel toggles and the machine returns to IDLE.
  - If the clear is still running at that edge, the swap waits for the next vblank edge.
  - swap_pending = (state == PENDING).
- **vblank_start** pulses on every vblank edge, whether or not a swap occurs.
- **Colour mapping, COLOR_MODE=1** (pixel d):
  - R = {d[7:5], d[7:5], d[7:6]}
  - G = {d[4:2], d[4:2], d[4:3]}
  - B = {d[1:0], d[1:0], d[1:0], d[1:0]}
- **Colour mapping, COLOR_MODE=0:** R = G = B = d.
- **Output gating.** RGB outputs are 0 whenever VGA_BLANK_N = 0.

## Timing
- **Reset values.** While reset is high:
  - hcount = vcount = 0, front_sel = 0, state IDLE.
  - clear_busy = swap_pending = vblank_start = 0.
  - VGA_BLANK_N = 0, pixel register = 0, so RGB = 0.
  - VGA_HS = VGA_VS = 1, VGA_SYNC_N = 1.
- **Reset mid-operation.** An in-flight clear aborts and a pending swap is discarded.
- **Memory contents** are not reset.
- **Read pipeline.**
  - Memory is read and the pixel register is loaded on cycles where hcount[0] = 1.
  - VGA_BLANK_N is registered on the same enable, so blank and data stay aligned.
  - Output data lags VGA_X by one pixel slot; the DAC latches on the rising edge of VGA_CLK.
- **Write visibility.** A write lands one cycle after the pixel_write edge. It appears on screen only after the next swap.
- **Clear duration.** Exactly HACTIVE*VACTIVE cycles from the clear_req edge to clear_busy falling; 307200 cycles at defaults.
- **Swap edge.** front_sel toggles on the same clock edge that vcount becomes VACTIVE, coincident with vblank_start.
- **Simultaneous events.**
  - swap_req on the vblank-edge cycle is not applied until the following frame.
  - clear_req and pixel_write in the same cycle: the clear wins and the write is dropped.

## Test plan
- **Reset.** Assert reset mid-frame. Required: all outputs at their listed reset values; after release, hcount and vcount restart at 0; VGA_HS goes low when p = 656 and stays low 192 cycles; VGA_VS goes low at vcount 490 for 2 lines.
- **Write then swap.** Write x=4, y=0, data 8'h7F, then swap_req. Required: front_sel toggles at the vcount 479->480 edge. Next frame: VGA_R = VGA_G = VGA_B = 8'h7F, one slot after VGA_X = 4 on line 0. Pixel 3 and pixel 5 read as 0.
- **No-swap isolation.** Write into the back buffer without swap_req. Required: displayed pixel is unchanged for 2 frames; vblank_start still pulses once per frame (every 840000 cycles).
- **Clear.** Fill pattern, then clear_req with CLEAR_VALUE 8'h00, then swap_req mid-clear. Required: clear_busy high for 307200 cycles; pixel_write ignored meanwhile; swap deferred to the first vblank edge after the clear completes; whole displayed frame reads 0.
- **Out of range.** Write x=640, y=0 and x=0, y=480 with data 8'hFF. Required: no memory location changes; pixel (0,0) and pixel (639,479) keep their prior values.
- **COLOR_MODE=1.** Write 8'hE3, then swap. Required: R = 8'hFF, G = 8'h00, B = 8'hFF on that pixel; all RGB outputs 0 throughout blanking.
